// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared defaults, bus register map and status-byte helper for the UART RX FIFO.
package uart_rx_fifo_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int THRESH_DEF     = 12;
  localparam int IDLE_CNT_W     = 11;

  typedef enum logic [3:0] {
    REG_STATUS  = 4'd8,
    REG_DATA    = 4'd9,
    REG_OVR_CLR = 4'd10
  } reg_off_e;

  localparam int ST_TX_IDLE_BIT   = 7;
  localparam int ST_NOT_EMPTY_BIT = 6;
  localparam int ST_OVERRUN_BIT   = 5;
  localparam int ST_FULL_BIT      = 4;

  function automatic logic [7:0] status_byte(input logic tx_idle, input logic not_empty,
                                             input logic overrun, input logic full);
    logic [7:0] s;
    s = '0;
    s[ST_TX_IDLE_BIT]   = tx_idle;
    s[ST_NOT_EMPTY_BIT] = not_empty;
    s[ST_OVERRUN_BIT]   = overrun;
    s[ST_FULL_BIT]      = full;
    return s;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, fill-count and full/empty bookkeeping for the RX FIFO.
module fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_req_i,
  input  logic                  pop_req_i,
  output logic                  push_o,
  output logic                  drop_o,
  output logic [DEPTH_LOG2-1:0] wr_ptr_o,
  output logic [DEPTH_LOG2-1:0] rd_ptr_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [DEPTH_LOG2:0]   count_d_o,
  output logic                  not_empty_o,
  output logic                  full_o
);

  localparam logic [DEPTH_LOG2:0]   DEPTH   = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  not_empty_q, full_q;
  logic                  pop, push;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  always_comb begin
    pop      = pop_req_i & not_empty_q;
    push     = push_req_i & (~full_q | pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      not_empty_q <= (count_d != '0);
      full_q      <= (count_d == DEPTH);
    end
  end

  assign push_o      = push;
  assign drop_o      = push_req_i & full_q & ~pop;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign count_d_o   = count_d;
  assign not_empty_o = not_empty_q;
  assign full_o      = full_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with show-ahead data, sticky overrun and active-low IRQ.
// Define RX_FIFO_THRESH_EN for fill-threshold plus idle-timeout interrupt.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
`ifdef RX_FIFO_THRESH_EN
  parameter int THRESH     = THRESH_DEF,
`endif
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      rx_data,
  input  logic                  rx_strobe,
  input  logic                  rd,
  input  logic                  ovr_clr,
  output logic [WIDTH-1:0]      dout,
  output logic                  not_empty,
  output logic                  full,
  output logic                  overrun,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  irq_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  push, drop;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  overrun_q, overrun_d;
  logic                  irq_n_q, irq_n_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  fifo_ctrl #(.DEPTH_LOG2(DEPTH_LOG2)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_req_i  (rx_strobe),
    .pop_req_i   (rd),
    .push_o      (push),
    .drop_o      (drop),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .count_d_o   (count_d),
    .not_empty_o (not_empty),
    .full_o      (full)
  );

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= rx_data;
  end

  // A fresh drop wins over a same-cycle clear.
  assign overrun_d = drop | (overrun_q & ~ovr_clr);

`ifdef RX_FIFO_THRESH_EN
  localparam logic [DEPTH_LOG2:0] THRESH_LVL = THRESH[DEPTH_LOG2:0];

  logic                  pop;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                  idle_to_q, idle_to_d;

  always_comb begin
    pop        = rd & not_empty;
    idle_cnt_d = '0;
    idle_to_d  = idle_to_q;
    if (not_empty && !push && !pop) begin
      idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
      if (idle_cnt_q == '1) idle_to_d = 1'b1;
    end
    if (pop) idle_to_d = 1'b0;
    irq_n_d = ~((count_d >= THRESH_LVL) | overrun_d | idle_to_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      idle_to_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      idle_to_q  <= idle_to_d;
    end
  end
`else
  assign irq_n_d = ~((count_d != '0) | overrun_d);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      overrun_q <= overrun_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign dout    = not_empty ? mem_q[rd_ptr] : '0;
  assign overrun = overrun_q;
  assign irq_n   = irq_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed vector bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_strobe, rd, ovr_clr;
  logic [7:0] dout;
  logic       not_empty, full, overrun, irq_n;
  logic [4:0] count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .rd        (rd),
    .ovr_clr   (ovr_clr),
    .dout      (dout),
    .not_empty (not_empty),
    .full      (full),
    .overrun   (overrun),
    .count     (count),
    .irq_n     (irq_n)
  );

  typedef struct {
    logic       strobe;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [7:0] e_dout;
    logic       e_ne;
    logic       e_full;
    logic       e_ovr;
    logic [4:0] e_cnt;
  } vec_t;

  vec_t tbl [10];

  function automatic logic exp_irq_n(input logic ne, input logic ovr, input logic [4:0] cnt);
`ifdef RX_FIFO_THRESH_EN
    return ~((cnt >= 5'd12) | ovr);
`else
    return ~(ne | ovr);
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] e_dout, input logic e_ne,
                         input logic e_full, input logic e_ovr, input logic [4:0] e_cnt);
    chk({name, ".dout"}, dout, e_dout);
    chk({name, ".not_empty"}, {7'd0, not_empty}, {7'd0, e_ne});
    chk({name, ".full"}, {7'd0, full}, {7'd0, e_full});
    chk({name, ".overrun"}, {7'd0, overrun}, {7'd0, e_ovr});
    chk({name, ".count"}, {3'd0, count}, {3'd0, e_cnt});
    chk({name, ".irq_n"}, {7'd0, irq_n}, {7'd0, exp_irq_n(e_ne, e_ovr, e_cnt)});
  endtask

  task automatic step(input logic s, input logic [7:0] d, input logic r, input logic c);
    rx_strobe = s;
    rx_data   = d;
    rd        = r;
    ovr_clr   = c;
    @(posedge clk);
    #1;
    rx_strobe = 1'b0;
    rd        = 1'b0;
    ovr_clr   = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input string name, input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      chk(name, dout, base + 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[4] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[5] = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[6] = '{1'b1, 8'h30, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 5'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0};

    rst_n = 1'b0; rx_data = 8'h00; rx_strobe = 1'b0; rd = 1'b0; ovr_clr = 1'b0;
    #12;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].strobe, tbl[i].data, tbl[i].rd, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_ne, tbl[i].e_full,
              tbl[i].e_ovr, tbl[i].e_cnt);
    end

    fill(8'h00);
    chk_all("fill1", 8'h00, 1'b1, 1'b1, 1'b0, 5'd16);
    drain("order1", 8'h00);
    chk_all("drain1", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
    fill(8'h80);
    chk_all("fill2", 8'h80, 1'b1, 1'b1, 1'b0, 5'd16);
    drain("order2", 8'h80);

    fill(8'h00);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk_all("ovr_set", 8'h00, 1'b1, 1'b1, 1'b1, 5'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("ovr_clr", 8'h00, 1'b1, 1'b1, 1'b0, 5'd16);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    chk_all("ovr_set_wins", 8'h00, 1'b1, 1'b1, 1'b1, 5'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("ovr_clr2", 8'h00, 1'b1, 1'b1, 1'b0, 5'd16);
    drain("ovr_order", 8'h00);
    chk_all("ovr_drained", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

    fill(8'hC0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk_all("full_pushpop", 8'hC1, 1'b1, 1'b1, 1'b0, 5'd16);
    for (int i = 1; i < 16; i++) begin
      chk("full_pushpop_order", dout, 8'hC0 + 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("full_pushpop_last", dout, 8'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("full_pushpop_empty", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    rx_strobe = 1'b1; rx_data = 8'h04;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    rx_strobe = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

`ifdef RX_FIFO_THRESH_EN
    for (int i = 0; i < 11; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    chk("thresh_11_irq_n", {7'd0, irq_n}, 8'h01);
    step(1'b1, 8'h6B, 1'b0, 1'b0);
    chk("thresh_12_irq_n", {7'd0, irq_n}, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("thresh_drained", {3'd0, count}, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2040; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_early_irq_n", {7'd0, irq_n}, 8'h01);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_timeout_irq_n", {7'd0, irq_n}, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("idle_cleared_irq_n", {7'd0, irq_n}, 8'h01);
    chk("idle_cleared_count", {3'd0, count}, 8'h02);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
